// File: rtl/paso_narrow_to_wide.sv
// Narrow-to-wide packer: gathers RATIO beats of IN_W bits into one IN_W*RATIO
// word. Supports lane order select, gap discard policy, padded partial-word
// flush, and a single output holding register with ready backpressure.
module paso_narrow_to_wide #(
  parameter int              IN_W      = 8,
  parameter int              RATIO     = 4,
  parameter bit              MSB_FIRST = 1'b1,
  parameter bit              GAP_MODE  = 1'b0,
  parameter logic [IN_W-1:0] PAD       = '0
) (
  input  logic                       clk_4f,
  input  logic                       reset,
  input  logic [IN_W-1:0]            data_in,
  input  logic                       valid_in,
  input  logic                       flush,
  input  logic                       ready_out,
  output logic [IN_W*RATIO-1:0]      data_out,
  output logic                       valid_out,
  output logic [$clog2(RATIO)-1:0]   lane_cnt,
  output logic                       overflow,
  output logic                       gap_drop
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = $clog2(RATIO);
  // fill count must be able to hold RATIO itself
  localparam int FW    = CW + 1;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  logic [RATIO-1:0][IN_W-1:0] acc_q, acc_d;
  logic [CW-1:0]              lane_cnt_q, lane_cnt_d;
  logic [OUT_W-1:0]           data_out_q, data_out_d;
  logic                       valid_out_q, valid_out_d;
  logic                       overflow_q, overflow_d;
  logic                       gap_drop_q, gap_drop_d;

  logic                       complete;
  logic                       do_flush;
  logic                       emit;
  logic                       gap;
  logic                       out_free;
  logic [FW-1:0]              fill;
  logic [RATIO-1:0][IN_W-1:0] word;
  logic [IN_W-1:0]            lane_val;

  // Event decode and assembly of the outgoing word, including a same-cycle beat
  always_comb begin
    complete = valid_in && (lane_cnt_q == LAST);
    fill     = FW'(lane_cnt_q) + FW'(valid_in);
    do_flush = flush && !complete && (fill != '0);
    emit     = complete || do_flush;
    gap      = GAP_MODE && !valid_in && !flush && (lane_cnt_q != '0);
    out_free = !valid_out_q || ready_out;
    word     = '0;
    lane_val = '0;
    for (int i = 0; i < RATIO; i++) begin
      lane_val = PAD;
      // lanes beyond the fill level are padded so stale beats never leak out
      if (FW'(i) < fill) begin
        if (valid_in && (lane_cnt_q == CW'(i))) lane_val = data_in;
        else                                    lane_val = acc_q[i];
      end
      if (MSB_FIRST) word[RATIO-1-i] = lane_val;
      else           word[i]         = lane_val;
    end
  end

  // Accumulator and lane counter update
  always_comb begin
    acc_d      = acc_q;
    lane_cnt_d = lane_cnt_q;
    if (valid_in) begin
      acc_d[lane_cnt_q] = data_in;
      lane_cnt_d        = lane_cnt_q + CW'(1);
    end
    if (emit || gap) begin
      acc_d      = '0;
      lane_cnt_d = '0;
    end
  end

  // Output holding register: load when free, otherwise drop and flag overflow
  always_comb begin
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q && !ready_out;
    overflow_d  = 1'b0;
    gap_drop_d  = gap;
    if (emit) begin
      if (out_free) begin
        data_out_d  = word;
        valid_out_d = 1'b1;
      end else begin
        overflow_d  = 1'b1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      acc_q       <= '0;
      lane_cnt_q  <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      gap_drop_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      lane_cnt_q  <= lane_cnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      overflow_q  <= overflow_d;
      gap_drop_q  <= gap_drop_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign lane_cnt  = lane_cnt_q;
  assign overflow  = overflow_q;
  assign gap_drop  = gap_drop_q;

endmodule

// File: tb/tb_paso_narrow_to_wide.sv
// Directed bench for paso_narrow_to_wide: three instances (default,
// LSB-first, gap-discard) share one stimulus stream; expected words are
// queued when the completing stimulus is driven and popped on output.
module tb_paso_narrow_to_wide;

  logic        clk_4f;
  logic        reset;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        flush;
  logic        ready_out;

  logic [31:0] d0_data, d1_data, d2_data;
  logic        d0_vld, d1_vld, d2_vld;
  logic [1:0]  d0_lane, d1_lane, d2_lane;
  logic        d0_ovf, d1_ovf, d2_ovf;
  logic        d0_gap, d1_gap, d2_gap;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  paso_narrow_to_wide #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b1), .GAP_MODE(1'b0), .PAD(8'h00)) dut0 (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .flush(flush), .ready_out(ready_out), .data_out(d0_data), .valid_out(d0_vld),
    .lane_cnt(d0_lane), .overflow(d0_ovf), .gap_drop(d0_gap));

  paso_narrow_to_wide #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b0), .GAP_MODE(1'b0), .PAD(8'h00)) dut1 (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .flush(flush), .ready_out(ready_out), .data_out(d1_data), .valid_out(d1_vld),
    .lane_cnt(d1_lane), .overflow(d1_ovf), .gap_drop(d1_gap));

  paso_narrow_to_wide #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b1), .GAP_MODE(1'b1), .PAD(8'h00)) dut2 (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .flush(flush), .ready_out(ready_out), .data_out(d2_data), .valid_out(d2_vld),
    .lane_cnt(d2_lane), .overflow(d2_ovf), .gap_drop(d2_gap));

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic drv(input logic v, input logic [7:0] d, input logic f);
    valid_in = v;
    data_in  = d;
    flush    = f;
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic vld, input logic [31:0] dat);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=%h expected=none_queued", tag, dat);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(vld), 32'd1);
      chk({tag, "_data"}, dat, e);
    end
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    valid_in = 1'b0;
    flush = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; data_in = '0; valid_in = 1'b0; flush = 1'b0; ready_out = 1'b1;
    tick(); tick();
    chk("rst_data", d0_data, 32'h0);
    chk("rst_valid", 32'(d0_vld), 32'd0);
    chk("rst_lane", 32'(d0_lane), 32'd0);
    chk("rst_ovf", 32'(d0_ovf), 32'd0);
    chk("rst_gap", 32'(d2_gap), 32'd0);
    reset = 1'b0;

    // 1: back-to-back words, MSB first
    drv(1, 8'h1F, 0); chk("t1_nv1", 32'(d0_vld), 32'd0);
    drv(1, 8'h2F, 0);
    drv(1, 8'h3F, 0); chk("t1_nv3", 32'(d0_vld), 32'd0);
    chk("t1_lane3", 32'(d0_lane), 32'd3);
    exp_q.push_back(32'h1F2F3F4F);
    drv(1, 8'h4F, 0); chk_word("t1_w0", d0_vld, d0_data);
    chk("t1_lane0", 32'(d0_lane), 32'd0);
    drv(1, 8'h1D, 0); chk("t1_drop", 32'(d0_vld), 32'd0);
    drv(1, 8'h2D, 0);
    drv(1, 8'h3D, 0);
    exp_q.push_back(32'h1D2D3D4D);
    drv(1, 8'h4D, 0); chk_word("t1_w1", d0_vld, d0_data);
    chk("t1_ovf", 32'(d0_ovf), 32'd0);

    // 2: LSB-first lane order
    rst_pulse();
    drv(1, 8'h00, 0); drv(1, 8'h00, 0); drv(1, 8'h00, 0);
    exp_q.push_back(32'h03000000);
    drv(1, 8'h03, 0); chk_word("t2_lsb", d1_vld, d1_data);

    // 3: backpressure and overflow
    rst_pulse();
    ready_out = 1'b0;
    drv(1, 8'hA1, 0); drv(1, 8'hA2, 0); drv(1, 8'hA3, 0);
    exp_q.push_back(32'hA1A2A3A4);
    drv(1, 8'hA4, 0); chk_word("t3_w0", d0_vld, d0_data);
    drv(1, 8'hB1, 0); chk("t3_hold1", d0_data, 32'hA1A2A3A4);
    drv(1, 8'hB2, 0); chk("t3_hold2", d0_data, 32'hA1A2A3A4);
    drv(1, 8'hB3, 0); chk("t3_novf", 32'(d0_ovf), 32'd0);
    drv(1, 8'hB4, 0); chk("t3_ovf", 32'(d0_ovf), 32'd1);
    chk("t3_hold4", d0_data, 32'hA1A2A3A4);
    drv(0, 8'h00, 0); chk("t3_ovf_pulse", 32'(d0_ovf), 32'd0);
    chk("t3_vld_held", 32'(d0_vld), 32'd1);
    ready_out = 1'b1;
    drv(0, 8'h00, 0); chk("t3_consumed", 32'(d0_vld), 32'd0);

    // 4: flush behaviour
    rst_pulse();
    drv(1, 8'hAA, 0);
    drv(1, 8'hBB, 0); chk("t4_lane2", 32'(d0_lane), 32'd2);
    exp_q.push_back(32'hAABB0000);
    drv(0, 8'h00, 1); chk_word("t4_flush", d0_vld, d0_data);
    chk("t4_lane_clr", 32'(d0_lane), 32'd0);
    drv(0, 8'h00, 0); chk("t4_idle", 32'(d0_vld), 32'd0);
    drv(0, 8'h00, 1); chk("t4_empty_flush", 32'(d0_vld), 32'd0);
    exp_q.push_back(32'hCC000000);
    drv(1, 8'hCC, 1); chk_word("t4_beat_flush", d0_vld, d0_data);
    chk("t4_bf_lane", 32'(d0_lane), 32'd0);
    drv(1, 8'h01, 0); drv(1, 8'h02, 0); drv(1, 8'h03, 0);
    exp_q.push_back(32'h01020304);
    drv(1, 8'h04, 1); chk_word("t4_full_flush", d0_vld, d0_data);
    chk("t4_ff_lane", 32'(d0_lane), 32'd0);

    // 5: gap policy
    rst_pulse();
    drv(1, 8'h11, 0); drv(1, 8'h22, 0);
    drv(0, 8'h00, 0);
    chk("t5_gapdrop", 32'(d2_gap), 32'd1);
    chk("t5_gap_lane", 32'(d2_lane), 32'd0);
    chk("t5_gap_nv", 32'(d2_vld), 32'd0);
    chk("t5_hold_lane", 32'(d0_lane), 32'd2);
    chk("t5_hold_nogap", 32'(d0_gap), 32'd0);
    drv(1, 8'h33, 0); chk("t5_gap_pulse", 32'(d2_gap), 32'd0);
    exp_q.push_back(32'h11223344);
    drv(1, 8'h44, 0); chk_word("t5_held_word", d0_vld, d0_data);
    chk("t5_gap_noword", 32'(d2_vld), 32'd0);
    chk("t5_gap_lane2", 32'(d2_lane), 32'd2);

    // 6: reset mid-word
    rst_pulse();
    drv(1, 8'h55, 0); drv(1, 8'h66, 0);
    rst_pulse();
    chk("t6_lane", 32'(d0_lane), 32'd0);
    chk("t6_valid", 32'(d0_vld), 32'd0);
    drv(1, 8'h71, 0); drv(1, 8'h72, 0); drv(1, 8'h73, 0);
    exp_q.push_back(32'h71727374);
    drv(1, 8'h74, 0); chk_word("t6_clean", d0_vld, d0_data);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
